// File: rtl/mem_access_unit.sv
// Memory access stage: accepts one EX instruction at a time, issues aligned load/store
// requests, waits for mem_ack with a bounded timeout, and produces a registered writeback pulse.
//
//   state | meaning
//   IDLE  | ready for an instruction; ALU ops and alignment faults complete from here
//   WAIT  | memory request outstanding; ends on mem_ack or wait-count expiry
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              regwe_i,
   input  logic              cregwa_i,
   input  logic              cregwd_i,
   input  logic              memre_i,
   input  logic              memwe_i,
   input  logic [1:0]        memlen_i,
   input  logic              memsext_i,
   input  logic [31:0]       aluout_i,
   input  logic [31:0]       rd2_i,
   input  logic [REG_AW-1:0] rt_i,
   input  logic [REG_AW-1:0] rd_i,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   output logic              we_o,
   output logic [REG_AW-1:0] wa_o,
   output logic [31:0]       wd_o,
   output logic              exc_align,
   output logic              exc_timeout,
   output logic              stall_o
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [REG_AW-1:0] lat_wa_q;
   logic              lat_regwe_q, lat_load_q, lat_cregwd_q, lat_sext_q;
   logic [1:0]        lat_len_q, lat_off_q;
   logic [31:0]       lat_alu_q;

   logic              accept, is_mem, misalign;
   logic [REG_AW-1:0] wa_sel;
   logic [3:0]        be_nx;
   logic [31:0]       wdata_nx, ld_shift, ld_data;

   logic              out_valid_d, we_d, exc_align_d, exc_timeout_d;
   logic              mem_req_d, mem_we_d;
   logic [REG_AW-1:0] wa_d;
   logic [31:0]       wd_d, mem_wdata_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [3:0]        mem_be_d;

   assign in_ready = (state_q == IDLE);
   assign stall_o  = ~in_ready;
   assign accept   = in_valid & in_ready;
   assign is_mem   = memre_i | memwe_i;
   assign wa_sel   = cregwa_i ? rd_i : rt_i;

   always_comb begin
      misalign = 1'b0;
      be_nx    = 4'b1111;
      wdata_nx = rd2_i;
      case (memlen_i)
         2'b00: begin
            be_nx    = 4'b0001 << aluout_i[1:0];
            wdata_nx = {4{rd2_i[7:0]}};
         end
         2'b01: begin
            misalign = aluout_i[0];
            be_nx    = 4'b0011 << aluout_i[1:0];
            wdata_nx = {2{rd2_i[15:0]}};
         end
         default: misalign = |aluout_i[1:0];
      endcase
   end

   // Move the addressed lane down to bit 0, then trim and extend to the access size.
   assign ld_shift = mem_rdata >> {lat_off_q, 3'b000};

   always_comb begin
      case (lat_len_q)
         2'b00:   ld_data = {{24{lat_sext_q & ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_data = {{16{lat_sext_q & ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (accept && is_mem && !misalign) begin
            state_d = WAIT;
            cnt_d   = '0;
         end
      end else if (mem_ack || (cnt_q == CNT_LAST)) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_comb begin
      out_valid_d   = 1'b0;
      exc_align_d   = 1'b0;
      exc_timeout_d = 1'b0;
      we_d          = we_o;
      wa_d          = wa_o;
      wd_d          = wd_o;
      mem_req_d     = mem_req;
      mem_we_d      = mem_we;
      mem_addr_d    = mem_addr;
      mem_be_d      = mem_be;
      mem_wdata_d   = mem_wdata;
      if (state_q == IDLE) begin
         if (accept) begin
            if (!is_mem) begin
               out_valid_d = 1'b1;
               we_d        = regwe_i;
               wa_d        = wa_sel;
               wd_d        = aluout_i;
            end else if (misalign) begin
               out_valid_d = 1'b1;
               exc_align_d = 1'b1;
               we_d        = 1'b0;
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = memwe_i;
               mem_addr_d  = ADDR_W'({aluout_i[31:2], 2'b00});
               mem_be_d    = be_nx;
               mem_wdata_d = wdata_nx;
            end
         end
      end else if (mem_ack) begin
         mem_req_d   = 1'b0;
         out_valid_d = 1'b1;
         we_d        = lat_regwe_q & lat_load_q;
         wa_d        = lat_wa_q;
         wd_d        = (lat_load_q & lat_cregwd_q) ? ld_data : lat_alu_q;
      end else if (cnt_q == CNT_LAST) begin
         mem_req_d     = 1'b0;
         out_valid_d   = 1'b1;
         exc_timeout_d = 1'b1;
         we_d          = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         we_o        <= 1'b0;
         wa_o        <= '0;
         wd_o        <= '0;
         exc_align   <= 1'b0;
         exc_timeout <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
      end else begin
         out_valid   <= out_valid_d;
         we_o        <= we_d;
         wa_o        <= wa_d;
         wd_o        <= wd_d;
         exc_align   <= exc_align_d;
         exc_timeout <= exc_timeout_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_be      <= mem_be_d;
         mem_wdata   <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_wa_q     <= '0;
         lat_regwe_q  <= 1'b0;
         lat_load_q   <= 1'b0;
         lat_cregwd_q <= 1'b0;
         lat_sext_q   <= 1'b0;
         lat_len_q    <= '0;
         lat_off_q    <= '0;
         lat_alu_q    <= '0;
      end else if (accept) begin
         lat_wa_q     <= wa_sel;
         lat_regwe_q  <= regwe_i;
         lat_load_q   <= memre_i;
         lat_cregwd_q <= cregwd_i;
         lat_sext_q   <= memsext_i;
         lat_len_q    <= memlen_i;
         lat_off_q    <= aluout_i[1:0];
         lat_alu_q    <= aluout_i;
      end
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, memory address width; REG_AW, default 5, register-address width; TIMEOUT, default 16, maximum wait cycles for mem_ack (legal range 2..255).
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  unit accepts an instruction this cycle
- regwe_i  in  1  instruction writes a register
- cregwa_i  in  1  destination select: 1 = rd_i, 0 = rt_i
- cregwd_i  in  1  writeback source: 1 = load data, 0 = aluout_i
- memre_i / memwe_i  in  1 each  load / store request (never both set)
- memlen_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- memsext_i  in  1  sign-extend loads (0 = zero-extend)
- aluout_i  in  32  ALU result; effective address for memory ops
- rd2_i  in  32  store data
- rt_i, rd_i  in  REG_AW each  candidate destination registers
- mem_req  out  1  memory request
- mem_we  out  1  request is a store
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  load data, valid with mem_ack
- out_valid  out  1  registered writeback result valid (one-cycle pulse)
- we_o  out  1  register write enable, qualified by out_valid
- wa_o  out  REG_AW  writeback register address
- wd_o  out  32  writeback data
- exc_align / exc_timeout  out  1 each  exception pulses coincident with out_valid
- stall_o  out  1  upstream stall request, equal to ~in_ready

Function
REQ-003 The FSM SHALL have states IDLE and WAIT; in_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE with in_valid=1, the unit SHALL latch all inputs; wa = cregwa_i ? rd_i : rt_i.
REQ-005 Non-memory instruction: out_valid SHALL pulse on the next cycle with wd_o=aluout_i, we_o=regwe_i; state stays IDLE; latency 1.
REQ-006 Alignment SHALL be checked in the accept cycle: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-007 A misaligned memory op SHALL issue no mem_req; on the next cycle out_valid=1, exc_align=1, we_o=0.
REQ-008 An aligned memory op SHALL move to WAIT with mem_req=1 starting the next cycle.
- mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable until acknowledged.
REQ-009 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-010 Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-011 In WAIT with mem_ack=1:
- mem_req SHALL drop on the next cycle and state SHALL return to IDLE.
- out_valid SHALL pulse on that same next cycle.
- For a load with cregwd=1: wd_o = mem_rdata>>(8*addr[1:0]), truncated to the access size, then sign- or zero-extended per memsext.
- Otherwise wd_o = aluout.
- we_o = regwe for loads, 0 for stores.
REQ-012 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
- When the count reaches TIMEOUT-1 with no ack, the request SHALL be abandoned and the unit SHALL return to IDLE.
- It SHALL then pulse out_valid with exc_timeout=1, we_o=0.
- An ack in that same cycle SHALL take priority as a normal completion.
REQ-013 Minimum memory-op latency SHALL be 2 cycles from accept to out_valid (ack in the first WAIT cycle).
REQ-014 in_valid while not in IDLE SHALL be ignored; the upstream stage holds its data under stall_o.
REQ-015 mem_ack outside WAIT SHALL be ignored.
REQ-016 Back-to-back instructions: a new accept SHALL be possible in the same cycle out_valid pulses.
REQ-017 we_o, wa_o and wd_o SHALL hold their last values between pulses; they are meaningful only with out_valid.

Reset
REQ-018 rst=0 SHALL asynchronously force:
- state to IDLE, wait counter to 0
- mem_req, mem_we, out_valid, we_o, exc_align and exc_timeout to 0
- mem_addr, mem_be, mem_wdata, wa_o and wd_o to 0
REQ-019 Reset during WAIT SHALL abandon the request with no out_valid; after release, in_ready=1 on the first clock.

Verification
REQ-020 ALU op: aluout=0x1234, regwe=1, cregwa=1, rd=7 -> next cycle out_valid=1, we_o=1, wa_o=7, wd_o=0x1234.
REQ-021 Signed byte load: addr=0x103, memsext=1, ack after 3 WAIT cycles with rdata=0x80FF_0000 -> mem_addr=0x100, mem_be=1000, wd_o=0xFFFFFF80.
REQ-022 Half store: addr=0x22, rd2=0xAAAA_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, we_o=0 on completion.
REQ-023 Word load at addr=0x06 -> no mem_req, out_valid with exc_align=1, we_o=0.
REQ-024 TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then exc_timeout=1, we_o=0, in_ready=1.
REQ-025 rst asserted mid-WAIT -> mem_req=0 immediately (asynchronous), no out_valid; a subsequent ALU op completes normally.
